dec_rr_arbiter: RTL and testbench

- Round-robin arbiter sharing one resource among 8 requesters.
- Grant is issued one-hot through the team's 3-to-8 decoder; the arbiter sequences that decoder's select and enable.
- Registered FSM with hold, release and wrap-around fairness.
- Sits between requesting agents and the shared resource; the one-hot grant drives the resource's per-agent select lines.

---
 rtl/dec_rr_arbiter_pkg.sv | 18 +
 rtl/dec_rr_arbiter_dec.sv | 20 ++
 rtl/dec_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_dec_rr_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_rr_arbiter_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dec_rr_arbiter_pkg;

    localparam int NUM_REQ = 8;
    localparam int ID_W    = 3;

    // The search begins at ptr+1, so resetting to the last agent makes agent 0 win first.
    localparam logic [ID_W-1:0] PTR_RESET = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dec_rr_arbiter_dec.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
// Latency: combinational.
// Backpressure: none.
module dec_rr_arbiter_dec
    import dec_rr_arbiter_pkg::*;
(
    input  logic [ID_W-1:0]    sel,
    input  logic               en,
    output logic [NUM_REQ-1:0] y
);

    // Drive exactly one line high for the selected index while enabled.
    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/dec_rr_arbiter.sv
// Round-robin arbiter for 8 agents; one-hot grant via the 3-to-8 decoder. Optional macro: ARB_HOLD_LIMIT_EN.
// Latency: 1 cycle from sampled req to grant; one dead cycle between consecutive owners.
// Backpressure: en low blocks new grants and releases the current one; unsampled req pulses are lost.
module dec_rr_arbiter
    import dec_rr_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [7:0]   req,
    output logic [7:0]   gnt,
    output logic [2:0]   gnt_id,
    output logic         gnt_vld,
    output logic         busy
`ifdef ARB_HOLD_LIMIT_EN
    ,
    output logic         hold_expired
`endif
);

    // The hold counter must be able to reach HOLD_MAX-1.
    if ((2 ** CNT_W) <= HOLD_MAX) begin : g_bad_hold_cfg
        $error("dec_rr_arbiter: CNT_W too narrow for HOLD_MAX");
    end

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   ptr_nxt;
    logic [ID_W-1:0]   id_nxt;
    logic [ID_W-1:0]   win;
    logic              hold_hit;

    // First set bit of r scanning p+1, p+2, ... modulo 8; p itself is checked last.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [ID_W-1:0]    p);
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] res;
        logic            found;
        res   = p;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = p + ID_W'(k);
            if (!found && r[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign win = rr_pick(req, ptr);

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0]   hold_cnt;
    logic [NUM_REQ-1:0] others;
    logic               force_rel;

    assign others    = req & ~(NUM_REQ'(1) << gnt_id);
    assign hold_hit  = (hold_cnt == HOLD_LAST) && (others != '0);
    // A forced release is one that happens only because the tenure limit was reached.
    assign force_rel = (state == ST_GRANT) && en && req[gnt_id] && hold_hit;

    // Tenure counter: cleared on entry to GRANT, counts GRANT cycles, saturates at HOLD_MAX-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt     <= '0;
            hold_expired <= 1'b0;
        end else begin
            hold_expired <= force_rel;
            if ((state != ST_GRANT) && (state_nxt == ST_GRANT)) begin
                hold_cnt <= '0;
            end else if ((state == ST_GRANT) && (hold_cnt != HOLD_LAST)) begin
                hold_cnt <= hold_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign hold_hit = 1'b0;
`endif

    // Next-state logic: arbitrate from IDLE/RELEASE, hold or release from GRANT.
    always_comb begin
        state_nxt = state;
        id_nxt    = gnt_id;
        ptr_nxt   = ptr;
        case (state)
            ST_IDLE, ST_RELEASE: begin
                if (en && (req != '0)) begin
                    state_nxt = ST_GRANT;
                    id_nxt    = win;
                    ptr_nxt   = win;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!en || !req[gnt_id] || hold_hit) begin
                    state_nxt = ST_RELEASE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, winner index and fairness pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            gnt_id <= '0;
            ptr    <= PTR_RESET;
        end else begin
            state  <= state_nxt;
            gnt_id <= id_nxt;
            ptr    <= ptr_nxt;
        end
    end

    // Outputs derive only from registered state, so the grant cannot glitch multi-hot.
    assign gnt_vld = (state == ST_GRANT);
    assign busy    = (state != ST_IDLE);

    dec_rr_arbiter_dec u_gnt_dec (
        .sel (gnt_id),
        .en  (gnt_vld),
        .y   (gnt)
    );

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// Self-checking bench for dec_rr_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against an owner/queue-level model.
// Build with +define+ARB_HOLD_LIMIT_EN to also exercise the tenure limit.
module tb_dec_rr_arbiter;

    localparam int HM = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_vld;
    logic       busy;
`ifdef ARB_HOLD_LIMIT_EN
    logic       hold_expired;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: current owner (-1 = none), last winner, dead-cycle flag, tenure count.
    int m_owner = -1;
    int m_id    = 0;
    int m_last  = 7;
    int m_cnt   = 0;
    bit m_dead  = 1'b0;
    bit m_exp   = 1'b0;

    dec_rr_arbiter #(.HOLD_MAX(HM), .CNT_W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .busy    (busy)
`ifdef ARB_HOLD_LIMIT_EN
        ,
        .hold_expired (hold_expired)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns the resource after each edge, from the arbitration rules.
    always @(posedge clk or negedge rst_n) begin : model
        int         o;
        int         id;
        int         last;
        int         cnt;
        bit         dead;
        bit         ex;
        logic [7:0] oth;
        if (!rst_n) begin
            m_owner <= -1;
            m_id    <= 0;
            m_last  <= 7;
            m_cnt   <= 0;
            m_dead  <= 1'b0;
            m_exp   <= 1'b0;
        end else begin
            o    = m_owner;
            id   = m_id;
            last = m_last;
            cnt  = m_cnt;
            dead = 1'b0;
            ex   = 1'b0;
            if (o >= 0) begin
                oth    = req;
                oth[o] = 1'b0;
                if (!en || !req[o]) begin
                    o    = -1;
                    dead = 1'b1;
                end else if (oth != 8'h00 && cnt == HM - 1 && `ifdef ARB_HOLD_LIMIT_EN 1'b1 `else 1'b0 `endif) begin
                    o    = -1;
                    dead = 1'b1;
                    ex   = 1'b1;
                end else if (cnt < HM - 1) begin
                    cnt = cnt + 1;
                end
            end else if (en && req != 8'h00) begin
                for (int k = 1; k <= 8; k++) begin
                    if (o < 0 && req[(last + k) % 8]) o = (last + k) % 8;
                end
                id   = o;
                last = o;
                cnt  = 0;
            end
            m_owner <= o;
            m_id    <= id;
            m_last  <= last;
            m_cnt   <= cnt;
            m_dead  <= dead;
            m_exp   <= ex;
        end
    end

    // Continuous comparison on the falling edge, away from the active edge.
    always @(negedge clk) begin : compare
        logic [7:0] eg;
        eg = 8'h00;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk("cmp_gnt", {24'h0, gnt}, {24'h0, eg});
        chk("cmp_gnt_vld", {31'h0, gnt_vld}, (m_owner >= 0) ? 32'd1 : 32'd0);
        chk("cmp_gnt_id", {29'h0, gnt_id}, m_id);
        chk("cmp_busy", {31'h0, busy}, (m_owner >= 0 || m_dead) ? 32'd1 : 32'd0);
`ifdef ARB_HOLD_LIMIT_EN
        chk("cmp_hold_expired", {31'h0, hold_expired}, {31'h0, m_exp});
`endif
    end

    // Drive inputs at a falling edge and advance to the next falling edge.
    task automatic tick(input logic e, input logic [7:0] r);
        en  = e;
        req = r;
        @(negedge clk);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic expect_out(input string nm, input logic [7:0] g, input logic [2:0] id,
                              input logic v, input logic b);
        chk({nm, "_gnt"}, {24'h0, gnt}, {24'h0, g});
        chk({nm, "_id"}, {29'h0, gnt_id}, {29'h0, id});
        chk({nm, "_vld"}, {31'h0, gnt_vld}, {31'h0, v});
        chk({nm, "_busy"}, {31'h0, busy}, {31'h0, b});
    endtask

    initial begin
        logic [7:0] r;
        logic       e;

        // Reset with every agent requesting.
        req = 8'hFF;
        en  = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        expect_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1, 8'hFF);
        expect_out("first_grant", 8'h01, 3'd0, 1'b1, 1'b1);

        // Fairness with agents 0 and 2.
        do_reset();
        tick(1'b1, 8'h05);
        expect_out("fair_a", 8'h01, 3'd0, 1'b1, 1'b1);
        tick(1'b1, 8'h04);
        expect_out("fair_gap1", 8'h00, 3'd0, 1'b0, 1'b1);
        tick(1'b1, 8'h05);
        expect_out("fair_b", 8'h04, 3'd2, 1'b1, 1'b1);
        tick(1'b1, 8'h01);
        expect_out("fair_gap2", 8'h00, 3'd2, 1'b0, 1'b1);
        tick(1'b1, 8'h05);
        expect_out("fair_c", 8'h01, 3'd0, 1'b1, 1'b1);

        // Wrap-around from agent 6 through 7 to 0.
        do_reset();
        tick(1'b1, 8'h40);
        expect_out("wrap_6", 8'h40, 3'd6, 1'b1, 1'b1);
        tick(1'b1, 8'h00);
        tick(1'b1, 8'h81);
        expect_out("wrap_7", 8'h80, 3'd7, 1'b1, 1'b1);
        tick(1'b1, 8'h01);
        expect_out("wrap_gap", 8'h00, 3'd7, 1'b0, 1'b1);
        tick(1'b1, 8'h81);
        expect_out("wrap_0", 8'h01, 3'd0, 1'b1, 1'b1);

        // Enable dropped during a grant to agent 3.
        do_reset();
        tick(1'b1, 8'h08);
        expect_out("en_grant", 8'h08, 3'd3, 1'b1, 1'b1);
        tick(1'b0, 8'h08);
        expect_out("en_release", 8'h00, 3'd3, 1'b0, 1'b1);
        tick(1'b0, 8'h08);
        expect_out("en_idle", 8'h00, 3'd3, 1'b0, 1'b0);
        tick(1'b0, 8'h28);
        expect_out("en_low_new_req", 8'h00, 3'd3, 1'b0, 1'b0);
        tick(1'b1, 8'h08);
        expect_out("en_regrant", 8'h08, 3'd3, 1'b1, 1'b1);

        // Asynchronous reset between edges while agent 4 holds the grant.
        tick(1'b1, 8'h00);
        tick(1'b1, 8'h10);
        expect_out("arst_pre", 8'h10, 3'd4, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        expect_out("arst_now", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1, 8'h30);
        expect_out("arst_after", 8'h10, 3'd4, 1'b1, 1'b1);

`ifdef ARB_HOLD_LIMIT_EN
        // Tenure limit with a competitor waiting.
        do_reset();
        for (int i = 0; i < HM; i++) begin
            tick(1'b1, 8'h03);
            expect_out("hold_tenure", 8'h01, 3'd0, 1'b1, 1'b1);
            chk("hold_no_pulse", {31'h0, hold_expired}, 32'd0);
        end
        tick(1'b1, 8'h03);
        expect_out("hold_gap", 8'h00, 3'd0, 1'b0, 1'b1);
        chk("hold_pulse", {31'h0, hold_expired}, 32'd1);
        tick(1'b1, 8'h03);
        expect_out("hold_next", 8'h02, 3'd1, 1'b1, 1'b1);
        chk("hold_pulse_end", {31'h0, hold_expired}, 32'd0);

        // Alone, the owner keeps the grant past the limit.
        do_reset();
        for (int i = 0; i < HM + 3; i++) begin
            tick(1'b1, 8'h01);
            expect_out("hold_alone", 8'h01, 3'd0, 1'b1, 1'b1);
            chk("hold_alone_pulse", {31'h0, hold_expired}, 32'd0);
        end
`endif

        // Randomized traffic; the owner tends to keep its request to build long tenures.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = 8'($urandom) & 8'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
            e = ($urandom_range(0, 9) != 0);
            en  = e;
            req = r;
            if (i % 700 == 350) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
